// File: rtl/pci_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// pci_pkg : command codes and initiator state type for the simplified PCI bus
// Rev 1.0 : initial release
// =============================================================================
package pci_pkg;

  localparam logic [3:0] PCI_READ  = 4'b0010;
  localparam logic [3:0] PCI_WRITE = 4'b0011;
  localparam logic [3:0] CBE_ALL   = 4'b1111;
  localparam logic [3:0] CBE_IDLE  = 4'b0000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_TURN  = 3'd2,
    ST_DATA  = 3'd3,
    ST_ABORT = 3'd4
  } init_state_e;

  function automatic logic [3:0] pci_cmd(input logic write);
    return write ? PCI_WRITE : PCI_READ;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pci_initiator.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// pci_initiator : bus-master end of the simplified PCI bus, one 1..MAX_WORDS
//                 burst per request, with DEVSEL timeout master abort.
// Rev 1.0 : initial release
// =============================================================================
module pci_initiator
  import pci_pkg::*;
#(
  parameter int DEVSEL_TIMEOUT = 5,
  parameter int MAX_WORDS      = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [31:0]                  req_addr,
  input  logic [$clog2(MAX_WORDS)-1:0] req_len,
  input  logic [32*MAX_WORDS-1:0]      req_wdata,
  output logic [31:0]                  rd_data,
  output logic                         rd_valid,
  output logic [$clog2(MAX_WORDS)-1:0] rd_index,
  output logic                         done,
  output logic                         abort,
  output logic                         busy,
  output logic                         FRAME_n,
  output logic                         IRDY_n,
  output logic [3:0]                   CBE,
  inout  wire  [31:0]                  AD,
  input  logic                         DEVSEL_n,
  input  logic                         TRDY_n
);

  localparam int         LW       = $clog2(MAX_WORDS);
  localparam logic [2:0] TMO_LAST = 3'(DEVSEL_TIMEOUT - 1);

  init_state_e              state_q;
  logic [LW-1:0]            cnt_q;
  logic [LW-1:0]            len_q;
  logic [2:0]               timer_q;
  logic                     dev_seen_q;
  logic                     write_q;
  logic [32*MAX_WORDS-1:0]  wdata_q;
  logic [31:0]              ad_out_q;
  logic                     ad_oe_q;
  logic                     frame_n_q;
  logic                     irdy_n_q;
  logic [3:0]               cbe_q;
  logic [31:0]              rd_data_q;
  logic                     rd_valid_q;
  logic [LW-1:0]            rd_index_q;
  logic                     done_q;
  logic                     abort_q;
  logic                     busy_q;
  logic                     req_ready_q;

  logic [LW-1:0]            cnt_d;
  logic [31:0]              word_d;
  logic                     xfer;
  logic                     count_en;
  logic                     timeout;

  // IRDY_n is held low for the whole DATA state, so TRDY_n alone marks a transfer
  assign xfer     = (state_q == ST_DATA) && !TRDY_n;
  assign count_en = ((state_q == ST_ADDR) || (state_q == ST_TURN) || (state_q == ST_DATA))
                    && DEVSEL_n && !dev_seen_q;
  assign timeout  = ((state_q == ST_TURN) || (state_q == ST_DATA)) && count_en
                    && (timer_q == TMO_LAST);
  assign cnt_d    = cnt_q + 1'b1;
  assign word_d   = wdata_q[{cnt_d, 5'd0} +: 32];

  assign AD        = ad_oe_q ? ad_out_q : 'z;
  assign FRAME_n   = frame_n_q;
  assign IRDY_n    = irdy_n_q;
  assign CBE       = cbe_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign rd_index  = rd_index_q;
  assign done      = done_q;
  assign abort     = abort_q;
  assign busy      = busy_q;
  assign req_ready = req_ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      timer_q     <= '0;
      dev_seen_q  <= 1'b0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      ad_out_q    <= '0;
      ad_oe_q     <= 1'b0;
      frame_n_q   <= 1'b1;
      irdy_n_q    <= 1'b1;
      cbe_q       <= CBE_IDLE;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_index_q  <= '0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      busy_q      <= 1'b0;
      req_ready_q <= 1'b1;
    end else begin
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;

      // Once DEVSEL_n has been seen low the timer freezes for the rest of the burst
      if (state_q == ST_IDLE) begin
        timer_q    <= '0;
        dev_seen_q <= 1'b0;
      end else if (!DEVSEL_n) begin
        dev_seen_q <= 1'b1;
      end else if (count_en) begin
        timer_q <= timer_q + 3'd1;
      end

      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            state_q     <= ST_ADDR;
            write_q     <= req_write;
            len_q       <= req_len;
            wdata_q     <= req_wdata;
            cnt_q       <= '0;
            frame_n_q   <= 1'b0;
            irdy_n_q    <= 1'b1;
            ad_out_q    <= req_addr;
            ad_oe_q     <= 1'b1;
            cbe_q       <= pci_cmd(req_write);
            busy_q      <= 1'b1;
            req_ready_q <= 1'b0;
          end
        end

        ST_ADDR: begin
          cbe_q <= CBE_ALL;
          if (write_q) begin
            state_q   <= ST_DATA;
            irdy_n_q  <= 1'b0;
            frame_n_q <= (len_q == '0);
            ad_out_q  <= wdata_q[31:0];
          end else begin
            state_q   <= ST_TURN;
            ad_oe_q   <= 1'b0;
          end
        end

        ST_TURN: begin
          irdy_n_q <= 1'b0;
          if (timeout) begin
            state_q   <= ST_ABORT;
            frame_n_q <= 1'b1;
          end else begin
            state_q   <= ST_DATA;
            frame_n_q <= (len_q == '0);
          end
        end

        ST_DATA: begin
          if (timeout) begin
            state_q   <= ST_ABORT;
            frame_n_q <= 1'b1;
          end else if (xfer) begin
            if (!write_q) begin
              rd_data_q  <= AD;
              rd_valid_q <= 1'b1;
              rd_index_q <= cnt_q;
            end
            cnt_q <= cnt_d;
            if (cnt_q == len_q) begin
              state_q     <= ST_IDLE;
              frame_n_q   <= 1'b1;
              irdy_n_q    <= 1'b1;
              ad_oe_q     <= 1'b0;
              cbe_q       <= CBE_IDLE;
              done_q      <= 1'b1;
              busy_q      <= 1'b0;
              req_ready_q <= 1'b1;
            end else begin
              frame_n_q <= (cnt_d == len_q);
              if (write_q) begin
                ad_out_q <= word_d;
              end
            end
          end
        end

        ST_ABORT: begin
          state_q     <= ST_IDLE;
          frame_n_q   <= 1'b1;
          irdy_n_q    <= 1'b1;
          ad_oe_q     <= 1'b0;
          cbe_q       <= CBE_IDLE;
          abort_q     <= 1'b1;
          busy_q      <= 1'b0;
          req_ready_q <= 1'b1;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/pci_initiator.md
# pci_initiator

- Bus-master (initiator) end of the team's simplified PCI bus.
- Takes a single-burst request from local logic (read or write, 1–4 words) and drives FRAME/IRDY/CBE/AD.
- Samples the target's DEVSEL/TRDY, returns read data word by word and reports completion or master abort.
- Sits opposite the existing PCI target model; used as the bench/SoC-side driver for it.

## Interface
Parameters:
- DEVSEL_TIMEOUT, 5: posedges without DEVSEL_n low after the address phase before master abort.
- MAX_WORDS, 4: burst length limit; fixes req_len and req_wdata widths.

Ports (name, direction, width, meaning):
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request strobe; accepted when req_ready=1.
- req_ready  out  1  high in IDLE only.
- req_write  in  1  1 = write (CMD 4'b0011), 0 = read (CMD 4'b0010).
- req_addr  in  32  target address driven in the address phase.
- req_len  in  2  burst length minus one (0 → 1 word, 3 → 4 words).
- req_wdata  in  128  write words; word i = bits [32i+31:32i].
- rd_data  out  32  read word.
- rd_valid  out  1  one-cycle pulse per read word.
- rd_index  out  2  index of the word on rd_data.
- done  out  1  one-cycle pulse at normal completion.
- abort  out  1  one-cycle pulse at master abort.
- busy  out  1  high from acceptance until return to IDLE.
- FRAME_n  out  1  active-low frame.
- IRDY_n  out  1  active-low initiator ready.
- CBE  out  4  command in the address phase, 4'b1111 in data phases, 4'b0000 in idle.
- AD  inout  32  address/data bus; tri-stated when not driven.
- DEVSEL_n  in  1  target device select.
- TRDY_n  in  1  target ready.

## Operation
States: IDLE, ADDR, TURN, DATA, ABORT.
- **IDLE**
  - FRAME_n=1, IRDY_n=1, AD=Z, CBE=0.
  - On req_valid, latch the request, clear word counter `cnt`, go to ADDR.
- **ADDR** (one cycle)
  - FRAME_n=0, IRDY_n=1, AD=req_addr, CBE=command.
  - Write → DATA; read → TURN.
- **TURN** (read only, one cycle)
  - AD=Z, IRDY_n=1, FRAME_n=0; then DATA.
- **DATA**
  - IRDY_n=0, CBE=4'b1111.
  - Write: AD=word[cnt]. Read: AD=Z.
  - FRAME_n=1 whenever the current phase is the last (cnt==req_len); otherwise FRAME_n=0.
  - A transfer completes on a posedge sampling IRDY_n=0 and TRDY_n=0. On that edge:
    - Read: rd_data ← AD, rd_valid=1, rd_index=cnt.
    - cnt increments.
  - TRDY_n=1 is a wait state: hold AD, IRDY_n and FRAME_n unchanged, indefinitely.
  - After the last transfer: FRAME_n=1, IRDY_n=1, AD=Z, done=1, go to IDLE.
- **Master abort**
  - A timer counts posedges from entry to TRDY/DATA while DEVSEL_n=1; it stops counting once DEVSEL_n=0 has been sampled.
  - At DEVSEL_TIMEOUT: go to ABORT for one cycle with FRAME_n=1, IRDY_n=0; then IRDY_n=1, AD=Z, abort=1, go to IDLE.
  - No rd_valid is issued after the abort decision.
- **Reset** (any state, mid-burst included): immediately IDLE, FRAME_n=1, IRDY_n=1, AD=Z, CBE=0, all pulses 0, req_ready=1, busy=0, rd_data=0.

## Timing
- Request accepted at edge N; ADDR phase visible after edge N.
- First write data phase starts one cycle after ADDR. First read data phase starts two cycles after ADDR (turnaround).
- Zero-wait burst of L words:
  - write: FRAME_n low L cycles (ADDR plus L−1 data phases); done pulses at the edge after the last transfer.
  - read: FRAME_n low for ADDR, TURN and L−1 data phases.
- rd_valid is coincident with the sampling edge (registered; visible the following cycle).
- Single-word burst: FRAME_n rises at the same edge IRDY_n falls.
- req_valid while busy is ignored (req_ready=0); no queuing.
- Simultaneous final TRDY_n=0 and timeout cannot occur: the timer stops once DEVSEL_n=0 has been seen.

## Structure
- Shared package `pci_pkg`:
  - PCI_READ=4'b0010, PCI_WRITE=4'b0011, CBE_ALL=4'b1111, CBE_IDLE=4'b0000.
  - Initiator state enum.
  - The target model reuses the command constants from this package.
- Single module, no sub-module.
- One FSM, a 3-bit abort timer and a 2-bit word counter.
- AD driven through one output-enable mux.

## Test plan
- Write, 4 words, addr 0x10, data 1001..1004, target zero-wait → 4 data phases with CBE=1111; FRAME_n high during word 4 only; target memory holds 1001..1004; one done pulse.
- Read, 4 words, addr 0x10, target inserts 1 wait state on word 2 → AD/IRDY_n held during the wait; rd_valid ×4 with rd_index 0..3; data equals target memory.
- Single-word write of 0xDEADBEEF → FRAME_n low exactly one cycle before IRDY_n falls; FRAME_n high in the data phase; done 1 cycle later.
- Address 0x20, no target responds → abort pulse 5 posedges after ADDR; FRAME_n/IRDY_n return high; no rd_valid; req_ready=1 afterwards.
- rst_n asserted mid-read after word 1 → outputs idle immediately, AD=Z; a new 2-word write afterwards completes normally.
- req_valid held high during a burst → second request only accepted after done.
